// File: rtl/hmac_engine_arbiter.sv
// Packet-granular round-robin arbiter sharing one hmac_verify engine between two AXI4SR hosts.
// An order FIFO records each grant so 1-bit verdicts are routed back to the requester in grant order.
module hmac_engine_arbiter #(
    parameter int DATA_BITS   = 512,
    parameter int ID_BITS     = 6,
    parameter int ORDER_DEPTH = 8
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic                           s0_axis_tvalid,
    output logic                           s0_axis_tready,
    input  logic [DATA_BITS-1:0]           s0_axis_tdata,
    input  logic [DATA_BITS/8-1:0]         s0_axis_tkeep,
    input  logic [ID_BITS-1:0]             s0_axis_tid,
    input  logic                           s0_axis_tlast,
    input  logic                           s1_axis_tvalid,
    output logic                           s1_axis_tready,
    input  logic [DATA_BITS-1:0]           s1_axis_tdata,
    input  logic [DATA_BITS/8-1:0]         s1_axis_tkeep,
    input  logic [ID_BITS-1:0]             s1_axis_tid,
    input  logic                           s1_axis_tlast,
    output logic                           m_eng_axis_tvalid,
    input  logic                           m_eng_axis_tready,
    output logic [DATA_BITS-1:0]           m_eng_axis_tdata,
    output logic [DATA_BITS/8-1:0]         m_eng_axis_tkeep,
    output logic [ID_BITS-1:0]             m_eng_axis_tid,
    output logic                           m_eng_axis_tlast,
    input  logic                           eng_res_tdata,
    input  logic                           eng_res_tvalid,
    output logic                           eng_res_tready,
    output logic                           res0_tdata,
    output logic                           res0_tvalid,
    input  logic                           res0_tready,
    output logic                           res1_tdata,
    output logic                           res1_tvalid,
    input  logic                           res1_tready,
    output logic [$clog2(ORDER_DEPTH):0]   outstanding,
    output logic                           busy
);
    localparam int PTR_W = $clog2(ORDER_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t                 r_state, w_state_nxt;
    logic                   r_gnt, r_last_gnt;
    logic [ORDER_DEPTH-1:0] r_order;
    logic [PTR_W-1:0]       r_wptr, r_rptr;
    logic [CNT_W-1:0]       r_outstanding;

    logic w_full, w_empty, w_push, w_pop, w_pick, w_head, w_sel_tvalid, w_sel_tlast;

    assign w_full  = (r_outstanding == CNT_W'(ORDER_DEPTH));
    assign w_empty = (r_outstanding == '0);

    // Data path is a plain mux on the owner; only valid/ready are gated by the lock.
    assign w_sel_tvalid     = r_gnt ? s1_axis_tvalid : s0_axis_tvalid;
    assign w_sel_tlast      = r_gnt ? s1_axis_tlast  : s0_axis_tlast;
    assign m_eng_axis_tdata = r_gnt ? s1_axis_tdata  : s0_axis_tdata;
    assign m_eng_axis_tkeep = r_gnt ? s1_axis_tkeep  : s0_axis_tkeep;
    assign m_eng_axis_tid   = r_gnt ? s1_axis_tid    : s0_axis_tid;
    assign m_eng_axis_tlast = w_sel_tlast;

    always_comb begin
        w_state_nxt       = r_state;
        w_push            = 1'b0;
        w_pick            = r_gnt;
        m_eng_axis_tvalid = 1'b0;
        s0_axis_tready    = 1'b0;
        s1_axis_tready    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_full && (s0_axis_tvalid || s1_axis_tvalid)) begin
                    w_push      = 1'b1;
                    w_pick      = (s0_axis_tvalid && s1_axis_tvalid) ? ~r_last_gnt : s1_axis_tvalid;
                    w_state_nxt = LOCK;
                end
            end
            LOCK: begin
                m_eng_axis_tvalid = w_sel_tvalid;
                s0_axis_tready    = !r_gnt && m_eng_axis_tready;
                s1_axis_tready    = r_gnt && m_eng_axis_tready;
                if (w_sel_tvalid && m_eng_axis_tready && w_sel_tlast)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Verdict routing follows the oldest outstanding grant; stalls while nothing is outstanding.
    assign w_head         = r_order[r_rptr];
    assign eng_res_tready = !w_empty && (w_head ? res1_tready : res0_tready);
    assign res0_tvalid    = !w_empty && !w_head && eng_res_tvalid;
    assign res1_tvalid    = !w_empty && w_head && eng_res_tvalid;
    assign res0_tdata     = eng_res_tdata;
    assign res1_tdata     = eng_res_tdata;
    assign w_pop          = eng_res_tvalid && eng_res_tready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state       <= IDLE;
            r_gnt         <= 1'b0;
            r_last_gnt    <= 1'b1;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_outstanding <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_gnt      <= w_pick;
                r_last_gnt <= w_pick;
                r_wptr     <= r_wptr + PTR_W'(1);
            end
            if (w_pop)
                r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (w_push)
            r_order[r_wptr] <= w_pick;
    end

    assign outstanding = r_outstanding;
    assign busy        = (r_state == LOCK);

endmodule
